// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment via bit-slip requests and symbol decode.
// Ports: pixel_clock/reset, tmds_word/tmds_valid in; bitslip, aligned, out_valid, de, data, ctrl out.
module tmds_channel_decoder #(
    parameter int CTRL_LOCK_COUNT = 8,
    parameter int SEARCH_TIMEOUT  = 64,
    parameter int SLIP_SETTLE     = 4,
    parameter int MAX_DATA_RUN    = 4096
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [9:0] tmds_word,
    input  logic       tmds_valid,
    output logic       bitslip,
    output logic       aligned,
    output logic       out_valid,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl
);

    localparam int TOK_W = $clog2(CTRL_LOCK_COUNT + 1);
    localparam int TMO_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SET_W = $clog2(SLIP_SETTLE + 1);
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

    localparam logic [TOK_W-1:0] TOK_MAX = TOK_W'(CTRL_LOCK_COUNT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(SEARCH_TIMEOUT);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(SLIP_SETTLE);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    // {is_token, c1, c0}
    function automatic logic [2:0] tok_decode(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'h354: r = 3'b100;
            10'h0AB: r = 3'b101;
            10'h154: r = 3'b110;
            10'h2AB: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sym_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    state_t           state_q, state_d;
    logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             bitslip_q, bitslip_d;

    logic [9:0]       s1_word_q, s1_word_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_lock_q, s1_lock_d;

    logic             out_valid_q, out_valid_d;
    logic             de_q, de_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       ctrl_q, ctrl_d;

    logic [2:0]       in_tok;
    logic [2:0]       s1_tok;
    logic [TOK_W-1:0] tok_nxt;
    logic [TMO_W-1:0] tmo_nxt;
    logic [SET_W-1:0] set_nxt;
    logic [RUN_W-1:0] run_nxt;

    // Alignment FSM: evaluated on the raw input word as it is sampled.
    always_comb begin
        state_d   = state_q;
        tok_cnt_d = tok_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        set_cnt_d = set_cnt_q;
        run_cnt_d = run_cnt_q;
        bitslip_d = 1'b0;
        in_tok    = tok_decode(tmds_word);

        tok_nxt = (tok_cnt_q == TOK_MAX) ? TOK_MAX : tok_cnt_q + 1'b1;
        tmo_nxt = (tmo_cnt_q == TMO_MAX) ? TMO_MAX : tmo_cnt_q + 1'b1;
        set_nxt = (set_cnt_q == SET_MAX) ? SET_MAX : set_cnt_q + 1'b1;
        run_nxt = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
        if (!in_tok[2]) begin
            tok_nxt = '0;
        end

        if (tmds_valid) begin
            case (state_q)
                SEARCH: begin
                    // Lock wins over timeout on the same word.
                    if (tok_nxt == TOK_MAX) begin
                        state_d   = LOCKED;
                        tok_cnt_d = '0;
                        tmo_cnt_d = '0;
                        run_cnt_d = '0;
                    end else if (tmo_nxt == TMO_MAX) begin
                        state_d   = SLIP_WAIT;
                        bitslip_d = 1'b1;
                        tok_cnt_d = '0;
                        tmo_cnt_d = '0;
                        set_cnt_d = '0;
                    end else begin
                        tok_cnt_d = tok_nxt;
                        tmo_cnt_d = tmo_nxt;
                    end
                end
                SLIP_WAIT: begin
                    if (set_nxt == SET_MAX) begin
                        state_d   = SEARCH;
                        set_cnt_d = '0;
                        tok_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        set_cnt_d = set_nxt;
                    end
                end
                LOCKED: begin
                    if (in_tok[2]) begin
                        run_cnt_d = '0;
                    end else if (run_nxt == RUN_MAX) begin
                        // Long data run: alignment is suspect, search again.
                        state_d   = SEARCH;
                        run_cnt_d = '0;
                        tok_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_nxt;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Stage 1 tags each word with whether it was sampled while locked,
    // which is what keeps the locking word itself off the output.
    always_comb begin
        s1_word_d  = tmds_valid ? tmds_word : s1_word_q;
        s1_valid_d = tmds_valid;
        s1_lock_d  = (state_q == LOCKED);
    end

    always_comb begin
        s1_tok      = tok_decode(s1_word_q);
        out_valid_d = s1_valid_q & s1_lock_q;
        de_d        = 1'b0;
        data_d      = 8'h00;
        ctrl_d      = ctrl_q;
        if (out_valid_d) begin
            if (s1_tok[2]) begin
                ctrl_d = s1_tok[1:0];
            end else begin
                de_d   = 1'b1;
                data_d = sym_decode(s1_word_q);
            end
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            tok_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            set_cnt_q   <= '0;
            run_cnt_q   <= '0;
            bitslip_q   <= 1'b0;
            s1_word_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_lock_q   <= 1'b0;
            out_valid_q <= 1'b0;
            de_q        <= 1'b0;
            data_q      <= 8'h00;
            ctrl_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            tok_cnt_q   <= tok_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            set_cnt_q   <= set_cnt_d;
            run_cnt_q   <= run_cnt_d;
            bitslip_q   <= bitslip_d;
            s1_word_q   <= s1_word_d;
            s1_valid_q  <= s1_valid_d;
            s1_lock_q   <= s1_lock_d;
            out_valid_q <= out_valid_d;
            de_q        <= de_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign bitslip   = bitslip_q;
    assign aligned   = (state_q == LOCKED);
    assign out_valid = out_valid_q;
    assign de        = de_q;
    assign data      = data_q;
    assign ctrl      = ctrl_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: directed stimulus with
// hand-computed expectations, checked by an independent output monitor.
module tb_tmds_channel_decoder;

    logic       pixel_clock = 1'b0;
    logic       reset;
    logic [9:0] tmds_word;
    logic       tmds_valid;
    logic       bitslip;
    logic       aligned;
    logic       out_valid;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;

    tmds_channel_decoder #(
        .CTRL_LOCK_COUNT(8),
        .SEARCH_TIMEOUT (64),
        .SLIP_SETTLE    (4),
        .MAX_DATA_RUN   (4096)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset      (reset),
        .tmds_word  (tmds_word),
        .tmds_valid (tmds_valid),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .out_valid  (out_valid),
        .de         (de),
        .data       (data),
        .ctrl       (ctrl)
    );

    always #5 pixel_clock = ~pixel_clock;

    int          vectors     = 0;
    int          miscompares = 0;
    int          slip_pulses = 0;
    logic        slip_prev   = 1'b0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_item;
    logic [1:0]  tb_ctrl;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: pops one expectation per valid output.
    always @(negedge pixel_clock) begin
        if (reset) begin
            slip_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got %0h expected none",
                             {de, data, ctrl});
                end else begin
                    exp_item = exp_q.pop_front();
                    check("scoreboard", {21'd0, de, data, ctrl},
                          {21'd0, exp_item});
                end
            end else if (de !== 1'b0 || data !== 8'h00) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_outputs: got de=%b data=%0h expected 0 0",
                         de, data);
            end
            if (bitslip) begin
                slip_pulses++;
                if (slip_prev) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bitslip_double: got 2 cycles expected 1");
                end
                if (aligned) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bitslip_locked: got 1 expected 0");
                end
            end
            slip_prev = bitslip;
        end
    end

    // Drive one word for one cycle. If push, the word is expected on the
    // output: tokens carry their fixed ctrl code, data words carry exp_d.
    task automatic step(input logic [9:0] w, input logic v,
                        input logic push, input logic [7:0] exp_d);
        tmds_word  = w;
        tmds_valid = v;
        if (push && v) begin
            case (w)
                10'h354: begin tb_ctrl = 2'b00; exp_q.push_back({1'b0, 8'h00, tb_ctrl}); end
                10'h0AB: begin tb_ctrl = 2'b01; exp_q.push_back({1'b0, 8'h00, tb_ctrl}); end
                10'h154: begin tb_ctrl = 2'b10; exp_q.push_back({1'b0, 8'h00, tb_ctrl}); end
                10'h2AB: begin tb_ctrl = 2'b11; exp_q.push_back({1'b0, 8'h00, tb_ctrl}); end
                default: exp_q.push_back({1'b1, exp_d, tb_ctrl});
            endcase
        end
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(10'h000, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
        logic [19:0] t;
        t = {w, w} << k;
        return t[19:10];
    endfunction

    initial begin
        int slips_before;
        int edge_n;
        int lock_edge;
        int k;
        int pulses[$];

        reset      = 1'b1;
        tmds_word  = '0;
        tmds_valid = 1'b0;
        tb_ctrl    = 2'b00;
        #12;
        check("reset_outputs",
              {19'd0, bitslip, aligned, out_valid, de, data, ctrl}, 32'd0);
        @(posedge pixel_clock);
        #1;
        reset = 1'b0;

        // Lock on eight 0x354 tokens; the locking word is not output.
        for (int i = 0; i < 7; i++) step(10'h354, 1'b1, 1'b0, 8'h00);
        check("t1_not_locked_7", {31'd0, aligned}, 32'd0);
        step(10'h354, 1'b1, 1'b0, 8'h00);
        check("t1_locked_8", {31'd0, aligned}, 32'd1);
        step(10'h0AB, 1'b1, 1'b1, 8'h00);
        idle(3);
        check("t1_ctrl_01", {30'd0, ctrl}, 32'd1);

        // Data decode, hand-computed.
        step(10'h100, 1'b1, 1'b1, 8'h00);
        step(10'h200, 1'b1, 1'b1, 8'hFF);
        step(10'h1FF, 1'b1, 1'b1, 8'h01);
        idle(1);
        step(10'h155, 1'b1, 1'b1, 8'hFF);
        step(10'h300, 1'b1, 1'b1, 8'h01);
        step(10'h0F0, 1'b1, 1'b1, 8'hEE);
        step(10'h2AB, 1'b1, 1'b1, 8'h00);
        step(10'h100, 1'b1, 1'b1, 8'h00);
        idle(3);
        check("t2_ctrl_held_11", {30'd0, ctrl}, 32'd3);

        // Long data run drops lock without a bitslip.
        slips_before = slip_pulses;
        step(10'h354, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 4095; i++) step(10'h100, 1'b1, 1'b1, 8'h00);
        check("t4_still_locked_4095", {31'd0, aligned}, 32'd1);
        step(10'h100, 1'b1, 1'b1, 8'h00);
        check("t4_unlocked_4096", {31'd0, aligned}, 32'd0);
        idle(3);
        check("t4_no_bitslip", slip_pulses, slips_before);

        // tmds_valid gaps freeze the search counters.
        for (int i = 0; i < 5; i++) step(10'h354, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) step(10'h354, 1'b0, 1'b0, 8'h00);
        check("t5_hold_unlocked", {31'd0, aligned}, 32'd0);
        step(10'h354, 1'b1, 1'b0, 8'h00);
        step(10'h354, 1'b1, 1'b0, 8'h00);
        check("t5_unlocked_7", {31'd0, aligned}, 32'd0);
        step(10'h354, 1'b1, 1'b0, 8'h00);
        check("t5_locked_8", {31'd0, aligned}, 32'd1);

        // Asynchronous reset while locked with words in flight.
        step(10'h0AB, 1'b1, 1'b1, 8'h00);
        step(10'h100, 1'b1, 1'b1, 8'h00);
        reset = 1'b1;
        #1;
        check("t6_reset_immediate",
              {19'd0, bitslip, aligned, out_valid, de, data, ctrl}, 32'd0);
        exp_q.delete();
        tb_ctrl = 2'b00;
        @(posedge pixel_clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) step(10'h354, 1'b1, 1'b0, 8'h00);
        check("t6_relock_7", {31'd0, aligned}, 32'd0);
        step(10'h354, 1'b1, 1'b0, 8'h00);
        check("t6_relock_8", {31'd0, aligned}, 32'd1);
        step(10'h154, 1'b1, 1'b1, 8'h00);
        idle(3);
        check("t6_ctrl_10", {30'd0, ctrl}, 32'd2);

        // Misaligned by 3 bits; each bitslip removes one bit of rotation.
        reset = 1'b1;
        @(posedge pixel_clock);
        #1;
        reset     = 1'b0;
        k         = 3;
        edge_n    = 0;
        lock_edge = -1;
        while (lock_edge < 0 && edge_n < 400) begin
            step(rotl(10'h354, k), 1'b1, 1'b0, 8'h00);
            edge_n++;
            if (bitslip) begin
                pulses.push_back(edge_n);
                if (k > 0) k--;
            end
            if (aligned) lock_edge = edge_n;
        end
        check("t3_pulse_count", pulses.size(), 3);
        check("t3_pulse0", (pulses.size() > 0) ? pulses[0] : -1, 64);
        check("t3_pulse1", (pulses.size() > 1) ? pulses[1] : -1, 132);
        check("t3_pulse2", (pulses.size() > 2) ? pulses[2] : -1, 200);
        check("t3_lock_edge", lock_edge, 212);
        idle(3);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
